eeg_aram_bank_rd: RTL and testbench

//  Per-bank activation-RAM port controller. Sits directly downstream of the ARAM router: consumes one

---
 rtl/eeg_aram_pkg.sv | 20 ++
 rtl/eeg_aram_rsp_buf.sv | 81 ++++++++
 rtl/eeg_aram_bank_rd.sv | 123 ++++++++++++
 tb/tb_eeg_aram_bank_rd.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/eeg_aram_pkg.sv
// ----------------------------------------------------------------------------
// eeg_aram_pkg
//   Shared constants and types for the activation-RAM bank controller.
//   ARAM_ADD_AW : default bank word-address width
//   ARAM_DAT_DW : default data word width (also fixes the response word type)
//   RSP_DEPTH   : default response-buffer depth (3 sustains one read per cycle)
//   aram_rsp_t  : one response-buffer entry, data word plus its burst-last flag
// ----------------------------------------------------------------------------
package eeg_aram_pkg;

    localparam int ARAM_ADD_AW = 12;
    localparam int ARAM_DAT_DW = 4;
    localparam int RSP_DEPTH   = 3;

    typedef struct packed {
        logic                   lst;
        logic [ARAM_DAT_DW-1:0] dat;
    } aram_rsp_t;

endpackage

// File: rtl/eeg_aram_rsp_buf.sv
// ----------------------------------------------------------------------------
// eeg_aram_rsp_buf
//   DEPTH-entry FIFO of aram_rsp_t with a registered head. Push and pop may
//   occur in the same cycle, including when full (the pop frees the slot the
//   push fills) and when empty (the pushed entry is visible next cycle).
//   Pointers wrap explicitly, so non-power-of-two depths are legal.
// Ports
//   clk, rst : clock, synchronous active-high reset
//   i_push   : write i_din into the tail
//   i_din    : entry to write
//   i_pop    : drop the head entry (ignored when empty)
//   o_head   : head entry, forced to zero when empty
//   o_empty  : no entries held
//   o_full   : DEPTH entries held
// ----------------------------------------------------------------------------
module eeg_aram_rsp_buf
    import eeg_aram_pkg::aram_rsp_t;
#(
    parameter int DEPTH = 3
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      i_push,
    input  aram_rsp_t i_din,
    input  logic      i_pop,
    output aram_rsp_t o_head,
    output logic      o_empty,
    output logic      o_full
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    aram_rsp_t     r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_cnt;
    logic          w_push;
    logic          w_pop;

    function automatic logic [PW-1:0] f_next(input logic [PW-1:0] ptr);
        return (ptr == PW'(DEPTH - 1)) ? '0 : ptr + 1'b1;
    endfunction

    assign o_empty = (r_cnt == '0);
    assign o_full  = (r_cnt == CW'(DEPTH));
    assign w_pop   = i_pop & ~o_empty;
    assign w_push  = i_push & (~o_full | w_pop);

    // Stale storage is never observable: the head is masked while empty.
    assign o_head  = o_empty ? '0 : r_mem[r_rd_ptr];

    // NOTE: storage has no reset; validity lives in r_cnt, so clearing the
    // array would only add reset fan-out without changing behaviour.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= f_next(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= f_next(r_rd_ptr);
            end
            if (w_push & ~w_pop) begin
                r_cnt <= r_cnt + 1'b1;
            end else if (w_pop & ~w_push) begin
                r_cnt <= r_cnt - 1'b1;
            end
        end
    end

endmodule

// File: rtl/eeg_aram_bank_rd.sv
// ----------------------------------------------------------------------------
// eeg_aram_bank_rd
//   Per-bank activation-RAM port controller. Accepts the granted AARB read
//   address stream, drives one single-port SRAM macro, and returns {lst,dat}
//   in request order. The activation-loader write port shares the macro and
//   always wins. A credit counter (in-flight + buffered reads) keeps every
//   issued read backed by a response-buffer slot, so nothing is dropped.
// Ports
//   clk, rst                 : clock, synchronous active-high reset
//   AARB_ADD_VLD/LST/RDY/ADD : read request stream (LST marks burst end)
//   AARB_DAT_VLD/LST/RDY/DAT : response stream, LST travels with its word
//   AWR_VLD/RDY/ADD/DAT      : bank write port, ready whenever out of reset
//   SRAM_CS/WE/ADD/DIN       : macro control, driven in the handshake cycle
//   SRAM_DOUT                : macro read data, valid the cycle after select
// ----------------------------------------------------------------------------
module eeg_aram_bank_rd
    import eeg_aram_pkg::aram_rsp_t;
#(
    parameter int ARAM_ADD_AW = eeg_aram_pkg::ARAM_ADD_AW,
    // Must match the width baked into aram_rsp_t.
    parameter int ARAM_DAT_DW = eeg_aram_pkg::ARAM_DAT_DW,
    parameter int RSP_DEPTH   = eeg_aram_pkg::RSP_DEPTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   AARB_ADD_VLD,
    input  logic                   AARB_ADD_LST,
    output logic                   AARB_ADD_RDY,
    input  logic [ARAM_ADD_AW-1:0] AARB_ADD_ADD,
    output logic                   AARB_DAT_VLD,
    output logic                   AARB_DAT_LST,
    input  logic                   AARB_DAT_RDY,
    output logic [ARAM_DAT_DW-1:0] AARB_DAT_DAT,
    input  logic                   AWR_VLD,
    output logic                   AWR_RDY,
    input  logic [ARAM_ADD_AW-1:0] AWR_ADD,
    input  logic [ARAM_DAT_DW-1:0] AWR_DAT,
    output logic                   SRAM_CS,
    output logic                   SRAM_WE,
    output logic [ARAM_ADD_AW-1:0] SRAM_ADD,
    output logic [ARAM_DAT_DW-1:0] SRAM_DIN,
    input  logic [ARAM_DAT_DW-1:0] SRAM_DOUT
);

    localparam int CW = $clog2(RSP_DEPTH + 1);

    logic          w_add_ena;
    logic          w_dat_ena;
    logic          w_wr_ena;
    logic [CW-1:0] r_cnt;
    logic          r_inf_vld;
    logic          r_inf_lst;
    aram_rsp_t     w_push_rsp;
    aram_rsp_t     w_head;
    logic          w_empty;
    logic          w_full;

    // Read acceptance depends only on registered credit and the write
    // request, never on AARB_DAT_RDY, so no ready-to-ready path exists.
    assign AWR_RDY      = ~rst;
    assign AARB_ADD_RDY = ~rst & ~AWR_VLD & (r_cnt < CW'(RSP_DEPTH));

    assign w_wr_ena  = AWR_VLD & AWR_RDY;
    assign w_add_ena = AARB_ADD_VLD & AARB_ADD_RDY;
    assign w_dat_ena = AARB_DAT_VLD & AARB_DAT_RDY;

    assign SRAM_CS  = w_add_ena | w_wr_ena;
    assign SRAM_WE  = w_wr_ena;
    assign SRAM_ADD = w_wr_ena ? AWR_ADD : AARB_ADD_ADD;
    assign SRAM_DIN = AWR_DAT;

    // NOTE: every clocked process uses non-blocking assignments so all
    // registers update together from the pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (w_add_ena & ~w_dat_ena) begin
            r_cnt <= r_cnt + 1'b1;
        end else if (w_dat_ena & ~w_add_ena) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    // The read issued this cycle returns on SRAM_DOUT next cycle; its LST
    // waits here so both enter the buffer together.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_inf_vld <= 1'b0;
            r_inf_lst <= 1'b0;
        end else begin
            r_inf_vld <= w_add_ena;
            if (w_add_ena) begin
                r_inf_lst <= AARB_ADD_LST;
            end
        end
    end

    assign w_push_rsp = '{lst: r_inf_lst, dat: SRAM_DOUT};

    eeg_aram_rsp_buf #(
        .DEPTH (RSP_DEPTH)
    ) u_rsp_buf (
        .clk     (clk),
        .rst     (rst),
        .i_push  (r_inf_vld),
        .i_din   (w_push_rsp),
        .i_pop   (w_dat_ena),
        .o_head  (w_head),
        .o_empty (w_empty),
        .o_full  (w_full)
    );

    assign AARB_DAT_VLD = ~w_empty;
    assign AARB_DAT_LST = w_head.lst;
    assign AARB_DAT_DAT = w_head.dat;

    a_credit_bound : assert property (@(posedge clk) disable iff (rst)
        r_cnt <= CW'(RSP_DEPTH));

    a_no_overflow : assert property (@(posedge clk) disable iff (rst)
        !(r_inf_vld && w_full && !w_dat_ena));

endmodule

// File: tb/tb_eeg_aram_bank_rd.sv
module tb_eeg_aram_bank_rd;

    localparam int AW    = 12;
    localparam int DW    = 4;
    localparam int DEPTH = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          add_vld, add_lst, add_rdy;
    logic [AW-1:0] add_add;
    logic          dat_vld, dat_lst, dat_rdy;
    logic [DW-1:0] dat_dat;
    logic          awr_vld, awr_rdy;
    logic [AW-1:0] awr_add;
    logic [DW-1:0] awr_dat;
    logic          sram_cs, sram_we;
    logic [AW-1:0] sram_add;
    logic [DW-1:0] sram_din;
    logic [DW-1:0] sram_dout = '0;

    always #5 clk = ~clk;

    eeg_aram_bank_rd u_dut (
        .clk          (clk),
        .rst          (rst),
        .AARB_ADD_VLD (add_vld),
        .AARB_ADD_LST (add_lst),
        .AARB_ADD_RDY (add_rdy),
        .AARB_ADD_ADD (add_add),
        .AARB_DAT_VLD (dat_vld),
        .AARB_DAT_LST (dat_lst),
        .AARB_DAT_RDY (dat_rdy),
        .AARB_DAT_DAT (dat_dat),
        .AWR_VLD      (awr_vld),
        .AWR_RDY      (awr_rdy),
        .AWR_ADD      (awr_add),
        .AWR_DAT      (awr_dat),
        .SRAM_CS      (sram_cs),
        .SRAM_WE      (sram_we),
        .SRAM_ADD     (sram_add),
        .SRAM_DIN     (sram_din),
        .SRAM_DOUT    (sram_dout)
    );

    // Single-port macro: one-cycle read latency.
    logic [DW-1:0] sram_mem [0:4095];
    always @(posedge clk) begin
        if (sram_cs) begin
            if (sram_we) sram_mem[sram_add] <= sram_din;
            else         sram_dout <= sram_mem[sram_add];
        end
    end

    // Reference model: bank contents plus an ordered list of accepted reads,
    // each visible two cycles after acceptance.
    typedef struct {
        logic          lst;
        logic [DW-1:0] dat;
        int            vis_cyc;
    } exp_t;

    exp_t          exp_q[$];
    logic [DW-1:0] ref_mem [0:4095];
    logic [DW-1:0] obs_q[$];
    logic          obs_last_lst;
    int            obs_first_cyc, obs_last_cyc;
    int            cyc = 0;
    int            n_acc = 0;
    int            n_checks = 0;
    int            n_fail = 0;
    bit            chk_en = 1'b0;
    bit            prev_stall = 1'b0;
    logic [DW-1:0] prev_dat;
    logic          prev_lst;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        bit   e_add_rdy, e_vld, wr_ena, add_ena, dat_ena;
        exp_t e;
        e_add_rdy = !rst && !awr_vld && (exp_q.size() < DEPTH);
        wr_ena    = !rst && awr_vld;
        add_ena   = add_vld && e_add_rdy;
        e_vld     = (exp_q.size() > 0) && (exp_q[0].vis_cyc <= cyc);
        dat_ena   = e_vld && dat_rdy;
        if (chk_en) begin
            check("add_rdy", add_rdy, e_add_rdy);
            check("awr_rdy", awr_rdy, !rst);
            check("dat_vld", dat_vld, e_vld);
            if (e_vld) begin
                check("dat_dat", dat_dat, exp_q[0].dat);
                check("dat_lst", dat_lst, exp_q[0].lst);
            end
            if (prev_stall) begin
                check("stall_dat_stable", dat_dat, prev_dat);
                check("stall_lst_stable", dat_lst, prev_lst);
            end
            check("sram_cs", sram_cs, wr_ena || add_ena);
            check("sram_we", sram_we, wr_ena);
            if (wr_ena || add_ena) check("sram_add", sram_add, wr_ena ? awr_add : add_add);
            if (wr_ena) check("sram_din", sram_din, awr_dat);
        end
        if (dat_vld === 1'b1 && dat_rdy) begin
            if (obs_q.size() == 0) obs_first_cyc = cyc;
            obs_q.push_back(dat_dat);
            obs_last_cyc = cyc;
            obs_last_lst = dat_lst;
        end
        prev_stall = chk_en && !rst && (dat_vld === 1'b1) && !dat_rdy;
        prev_dat   = dat_dat;
        prev_lst   = dat_lst;
        if (rst) begin
            exp_q.delete();
        end else begin
            if (dat_ena) void'(exp_q.pop_front());
            if (add_ena) begin
                e.lst     = add_lst;
                e.dat     = ref_mem[add_add];
                e.vis_cyc = cyc + 2;
                exp_q.push_back(e);
                n_acc++;
            end
            if (wr_ena) ref_mem[awr_add] = awr_dat;
        end
        cyc++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write(input int a, input int d);
        awr_vld = 1'b1;
        awr_add = AW'(a);
        awr_dat = DW'(d);
        tick();
        awr_vld = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int acc, k, start;
        bit resumed;
        for (int i = 0; i < 4096; i++) begin
            sram_mem[i] = '0;
            ref_mem[i]  = '0;
        end
        rst = 1'b1; add_vld = 1'b1; add_lst = 1'b0; add_add = '0;
        dat_rdy = 1'b1; awr_vld = 1'b1; awr_add = '0; awr_dat = 4'hF;
        repeat (3) tick();

        // Reset state, with both request valids high.
        @(negedge clk);
        check("rst_add_rdy", add_rdy, 0);
        check("rst_awr_rdy", awr_rdy, 0);
        check("rst_dat_vld", dat_vld, 0);
        check("rst_dat_lst", dat_lst, 0);
        check("rst_dat_dat", dat_dat, 0);
        check("rst_sram_cs", sram_cs, 0);
        check("rst_sram_we", sram_we, 0);
        tick();
        add_vld = 1'b0; awr_vld = 1'b0; rst = 1'b0;
        chk_en = 1'b1;
        tick();

        // 1: single read, latency two, one beat.
        write(5, 'hA);
        add_vld = 1'b1; add_add = 5; add_lst = 1'b1;
        @(negedge clk); check("t1_accept", add_rdy, 1);
        tick(); add_vld = 1'b0; add_lst = 1'b0;
        @(negedge clk); check("t1_not_yet", dat_vld, 0);
        tick();
        @(negedge clk);
        check("t1_vld", dat_vld, 1);
        check("t1_dat", dat_dat, 'hA);
        check("t1_lst", dat_lst, 1);
        tick();
        @(negedge clk); check("t1_one_beat", dat_vld, 0);
        tick();

        // 2: burst 0..7 at full rate.
        for (int i = 0; i < 8; i++) write(i, i);
        obs_q.delete();
        for (int i = 0; i < 8; i++) begin
            add_vld = 1'b1; add_add = AW'(i); add_lst = (i == 7);
            @(negedge clk); check("t2_rdy_held", add_rdy, 1);
            tick();
        end
        add_vld = 1'b0; add_lst = 1'b0;
        repeat (4) tick();
        check("t2_beats", obs_q.size(), 8);
        check("t2_consecutive", obs_last_cyc - obs_first_cyc, 7);
        check("t2_last_dat", obs_q.size() > 0 ? obs_q[obs_q.size()-1] : 'x, 7);
        check("t2_last_lst", obs_last_lst, 1);

        // 3: consumer stalled, credits run out at three.
        dat_rdy = 1'b0; add_vld = 1'b1; add_add = 1; acc = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk); if (add_rdy) acc++;
            tick(); add_add = AW'(1 + acc);
        end
        check("t3_accepts", acc, 3);
        @(negedge clk);
        check("t3_head_vld", dat_vld, 1);
        check("t3_head_dat", dat_dat, 1);
        obs_q.delete();
        tick(); dat_rdy = 1'b1; resumed = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); if (add_rdy) resumed = 1'b1;
            tick();
        end
        check("t3_resume", resumed, 1);
        add_vld = 1'b0;
        repeat (8) tick();
        check("t3_beats_ge3", obs_q.size() >= 3, 1);
        for (int j = 0; j < 3; j++)
            check("t3_order", (j < obs_q.size()) ? obs_q[j] : 'x, j + 1);

        // 4: write and read to the same address in the same cycle.
        write(9, 1);
        obs_q.delete();
        awr_vld = 1'b1; awr_add = 9; awr_dat = 6;
        add_vld = 1'b1; add_add = 9; add_lst = 1'b1;
        @(negedge clk);
        check("t4_read_blocked", add_rdy, 0);
        check("t4_we", sram_we, 1);
        check("t4_sram_add", sram_add, 9);
        tick(); awr_vld = 1'b0;
        @(negedge clk); check("t4_read_accept", add_rdy, 1);
        tick(); add_vld = 1'b0; add_lst = 1'b0;
        repeat (4) tick();
        check("t4_beats", obs_q.size(), 1);
        check("t4_new_data", obs_q.size() > 0 ? obs_q[0] : 'x, 6);

        // 5: reset with reads outstanding.
        dat_rdy = 1'b0; add_vld = 1'b1; add_add = 2; add_lst = 1'b0;
        repeat (3) tick();
        add_vld = 1'b0; rst = 1'b1;
        tick(); rst = 1'b0;
        @(negedge clk);
        check("t5_dat_vld", dat_vld, 0);
        check("t5_dat_lst", dat_lst, 0);
        check("t5_dat_dat", dat_dat, 0);
        check("t5_sram_cs", sram_cs, 0);
        check("t5_credit_free", add_rdy, 1);
        obs_q.delete();
        tick(); dat_rdy = 1'b1;
        repeat (6) tick();
        check("t5_no_stale", obs_q.size(), 0);
        dat_rdy = 1'b0; add_vld = 1'b1; acc = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk); if (add_rdy) acc++;
            tick();
        end
        check("t5_full_credit", acc, 3);
        add_vld = 1'b0; dat_rdy = 1'b1;
        repeat (6) tick();

        // 6: random reads, writes and back-pressure against the model.
        start = n_acc; k = 0;
        while ((n_acc - start < 200) && (k < 5000)) begin
            add_vld = ($urandom_range(0, 3) != 0);
            add_add = AW'($urandom_range(0, 15));
            add_lst = 1'($urandom_range(0, 1));
            awr_vld = ($urandom_range(0, 7) == 0);
            awr_add = AW'($urandom_range(0, 15));
            awr_dat = DW'($urandom_range(0, 15));
            dat_rdy = 1'($urandom_range(0, 1));
            tick(); k++;
        end
        check("t6_reads_done", (n_acc - start) >= 200, 1);
        add_vld = 1'b0; awr_vld = 1'b0; dat_rdy = 1'b1; k = 0;
        while ((exp_q.size() != 0) && (k < 50)) begin
            tick(); k++;
        end
        check("t6_drained", exp_q.size(), 0);
        @(negedge clk); check("t6_idle_vld", dat_vld, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
